rom_load_sequencer: RTL

- Sits between hps_io's ioctl download interface and the ckong core's ROM write ports.
- Decodes the linear MRA byte stream into four region write ports: CPU program, sound, tile graphics and sprite graphics/palette PROMs.
- Counts and validates the loaded length.
- Sequences the core reset: held during download, released a fixed time after a valid load, and re-asserted on user reset requests.

---
 rtl/rom_load_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: turns the hps_io ioctl byte stream into four ROM region
// write ports, checks the downloaded length and sequences the ckong core reset.
module rom_load_sequencer #(
    parameter logic [16:0] B1          = 17'h06000,
    parameter logic [16:0] B2          = 17'h08000,
    parameter logic [16:0] B3          = 17'h0C000,
    parameter logic [16:0] TOTAL       = 17'h10100,
    parameter logic [15:0] HOLD_CYCLES = 16'd1024
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        rst_req,
    output logic [3:0]  rgn_wr,
    output logic [16:0] rgn_addr,
    output logic [7:0]  rgn_data,
    output logic        core_reset,
    output logic        load_ok,
    output logic        load_err
);

    // A hold length of zero still gives one cycle of reset.
    localparam logic [15:0] HOLD_LAST = (HOLD_CYCLES == 16'd0) ? 16'd0 : HOLD_CYCLES - 16'd1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_HOLD, S_RUN, S_ERR} state_t;

    state_t      state;
    logic        dl_q;
    logic [17:0] byte_cnt;
    logic [15:0] hold_cnt;
    logic        ovf;

    logic [16:0] a;
    logic        in_range;
    logic        dl_start;
    logic [3:0]  dec_wr;
    logic [16:0] dec_off;

    assign a        = ioctl_addr[16:0];
    assign in_range = (ioctl_addr[24:17] == 8'd0) && (a < TOTAL);
    assign dl_start = ioctl_download & ~dl_q;

    // Region decode: one-hot select plus offset from the region base.
    always_comb begin
        dec_wr  = 4'b0000;
        dec_off = 17'd0;
        if (a < B1) begin
            dec_wr  = 4'b0001;
            dec_off = a;
        end else if (a < B2) begin
            dec_wr  = 4'b0010;
            dec_off = a - B1;
        end else if (a < B3) begin
            dec_wr  = 4'b0100;
            dec_off = a - B2;
        end else begin
            dec_wr  = 4'b1000;
            dec_off = a - B3;
        end
    end

    // Sequencer FSM with registered region port and reset/status outputs.
    // dl_q resets high so a download already in progress across reset_n is
    // not picked up until ioctl_download is seen rising again.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            dl_q       <= 1'b1;
            byte_cnt   <= '0;
            hold_cnt   <= '0;
            ovf        <= 1'b0;
            rgn_wr     <= '0;
            rgn_addr   <= '0;
            rgn_data   <= '0;
            core_reset <= 1'b1;
            load_ok    <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            dl_q   <= ioctl_download;
            rgn_wr <= 4'b0000;
            // A new download start wins over everything outside an active load.
            if (dl_start && state != S_LOAD && state != S_CHECK) begin
                state      <= S_LOAD;
                byte_cnt   <= '0;
                ovf        <= 1'b0;
                load_ok    <= 1'b0;
                load_err   <= 1'b0;
                core_reset <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: core_reset <= 1'b1;
                    S_LOAD: begin
                        // A strobe on the same cycle as the download fall still counts.
                        if (ioctl_wr) begin
                            if (in_range) begin
                                rgn_wr   <= dec_wr;
                                rgn_addr <= dec_off;
                                rgn_data <= ioctl_dout;
                                if (byte_cnt != '1)
                                    byte_cnt <= byte_cnt + 18'd1;
                            end else begin
                                ovf <= 1'b1;
                            end
                        end
                        if (!ioctl_download)
                            state <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (byte_cnt == {1'b0, TOTAL} && !ovf) begin
                            load_ok  <= 1'b1;
                            hold_cnt <= '0;
                            state    <= S_HOLD;
                        end else begin
                            load_err <= 1'b1;
                            state    <= S_ERR;
                        end
                    end
                    S_HOLD: begin
                        if (rst_req) begin
                            hold_cnt <= '0;
                        end else if (hold_cnt == HOLD_LAST) begin
                            state      <= S_RUN;
                            core_reset <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt + 16'd1;
                        end
                    end
                    S_RUN: begin
                        if (rst_req) begin
                            state      <= S_HOLD;
                            hold_cnt   <= '0;
                            core_reset <= 1'b1;
                        end
                    end
                    S_ERR:   core_reset <= 1'b1;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
